layer_serializer: RTL and testbench

LAYER_SERIALIZER -- requirements
Module: layer_serializer

---
 rtl/layer_ser_pkg.sv | 18 +
 rtl/layer_serializer.sv | 157 +++++++++++++++
 tb/tb_layer_serializer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_ser_pkg.sv
// rtl/layer_ser_pkg.sv - shared state encoding and index-width helper for layer_serializer
package layer_ser_pkg;

  // Serializer control states: waiting for a vector, or streaming one out.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Narrowest usable index port, so degenerate sizes still get a real bit.
  localparam int unsigned MIN_INDEX_W = 1;

  // Width of an element index for a vector of n elements.
  function automatic int unsigned index_width(input int unsigned n);
    return (n < 2) ? MIN_INDEX_W : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - parallel neuron vector to serial element stream; optional ReLU clamp via LAYER_SER_RELU_EN
module layer_serializer
  import layer_ser_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = 16,
  parameter int unsigned NUM_NEURONS = 30,
  parameter bit          LSB_FIRST   = 1'b1
) (
  input  logic                                  s_axi_aclk,
  input  logic                                  s_axi_aresetn,
  input  logic [NUM_NEURONS-1:0]                in_valid,
  input  logic [DATAWIDTH*NUM_NEURONS-1:0]      in_data,
  output logic                                  in_ready,
  output logic                                  out_valid,
  output logic [DATAWIDTH-1:0]                  out_data,
  output logic                                  out_last,
  output logic [index_width(NUM_NEURONS)-1:0]   out_index,
  input  logic                                  out_ready,
  output logic                                  drop
);

  localparam int unsigned     IDX_W    = index_width(NUM_NEURONS);
  localparam int unsigned     VEC_W    = DATAWIDTH * NUM_NEURONS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  ser_state_t       state;
  ser_state_t       state_next;
  logic             pending_full;
  logic [VEC_W-1:0] pending_buf;
  logic [VEC_W-1:0] active_buf;
  logic [VEC_W-1:0] in_ordered;
  logic [DATAWIDTH-1:0] head;

  logic offered;
  logic accept;
  logic handshake;
  logic last_hs;
  logic load_input;
  logic load_pending;
  logic store_pending;

  // Rearrange a vector so the element to be sent first sits in the low slot;
  // the active buffer then only ever shifts down and out_data is its low slot.
  function automatic logic [VEC_W-1:0] send_order(input logic [VEC_W-1:0] vec);
    logic [VEC_W-1:0] r;
    r = vec;
    if (!LSB_FIRST) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r[i*DATAWIDTH +: DATAWIDTH] = vec[(NUM_NEURONS-1-i)*DATAWIDTH +: DATAWIDTH];
      end
    end
    return r;
  endfunction

  assign in_ordered = send_order(in_data);

  // A vector counts only when every neuron of the producing layer is valid.
  assign offered   = &in_valid;
  assign in_ready  = ~pending_full;
  assign accept    = offered & in_ready;

  assign out_valid = (state == SEND);
  assign handshake = out_valid & out_ready;
  assign out_last  = out_valid & (out_index == LAST_IDX);
  assign last_hs   = handshake & out_last;

  assign head = active_buf[DATAWIDTH-1:0];

`ifdef LAYER_SER_RELU_EN
  // Negative values are clamped to zero on the way out.
  assign out_data = head[DATAWIDTH-1] ? '0 : head;
`else
  assign out_data = head;
`endif

  // State register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and buffer-steering decisions.
  always_comb begin
    state_next    = state;
    load_input    = 1'b0;
    load_pending  = 1'b0;
    store_pending = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load_input = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (last_hs) begin
          // Refill straight away so the next vector follows without a bubble.
          if (pending_full) begin
            load_pending = 1'b1;
          end else if (accept) begin
            load_input = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (accept) begin
          store_pending = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Single pending slot that parks a vector arriving mid-stream.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      pending_full <= 1'b0;
      pending_buf  <= '0;
    end else if (store_pending) begin
      pending_full <= 1'b1;
      pending_buf  <= in_ordered;
    end else if (load_pending) begin
      pending_full <= 1'b0;
    end
  end

  // Active buffer shifts one element per handshake; index restarts per vector.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      active_buf <= '0;
      out_index  <= '0;
    end else if (load_input) begin
      active_buf <= in_ordered;
      out_index  <= '0;
    end else if (load_pending) begin
      active_buf <= pending_buf;
      out_index  <= '0;
    end else if (handshake) begin
      active_buf <= {{DATAWIDTH{1'b0}}, active_buf[VEC_W-1:DATAWIDTH]};
      out_index  <= last_hs ? '0 : out_index + IDX_W'(1);
    end
  end

  // One-cycle loss indication for a vector offered while the slot is full.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      drop <= 1'b0;
    end else begin
      drop <= offered & pending_full;
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - scoreboard bench for layer_serializer (LSB-first and MSB-first instances)
module tb_layer_serializer;

  localparam int DW = 16;
  localparam int NN = 4;
  localparam int IW = 2;

  localparam logic [DW*NN-1:0] V1 = 64'h0004_0003_0002_0001;
  localparam logic [DW*NN-1:0] V2 = 64'h0008_0007_0006_0005;
  localparam logic [DW*NN-1:0] V3 = 64'h00AA_00BB_00CC_00DD;
  localparam logic [DW*NN-1:0] V4 = 64'h0010_FFFE_7FFF_8000;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NN-1:0]    in_valid = '0;
  logic [DW*NN-1:0] in_data = '0;
  logic             out_ready = 1'b0;

  logic             in_ready_a, out_valid_a, out_last_a, drop_a;
  logic [DW-1:0]    out_data_a;
  logic [IW-1:0]    out_index_a;
  logic             in_ready_b, out_valid_b, out_last_b, drop_b;
  logic [DW-1:0]    out_data_b;
  logic [IW-1:0]    out_index_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   passed = 0;
  int   total  = 0;

  layer_serializer #(.DATAWIDTH(DW), .NUM_NEURONS(NN), .LSB_FIRST(1'b1)) dut_a (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .out_last(out_last_a), .out_index(out_index_a), .out_ready(out_ready), .drop(drop_a)
  );

  layer_serializer #(.DATAWIDTH(DW), .NUM_NEURONS(NN), .LSB_FIRST(1'b0)) dut_b (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
    .out_last(out_last_b), .out_index(out_index_b), .out_ready(out_ready), .drop(drop_b)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_elem(input logic [DW-1:0] v);
`ifdef LAYER_SER_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic push_vec(input logic [DW*NN-1:0] v);
    exp_t e;
    for (int i = 0; i < NN; i++) begin
      e.idx  = IW'(i);
      e.last = (i == NN - 1);
      e.data = model_elem(v[i*DW +: DW]);
      q_a.push_back(e);
      e.data = model_elem(v[(NN-1-i)*DW +: DW]);
      q_b.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready_a !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready_a); else passed++;
    total++; if (out_valid_a !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid_a); else passed++;
    total++; if (out_last_a !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last_a); else passed++;
    total++; if (out_index_a !== '0) $display("FAIL reset_out_index got %0d want 0", out_index_a); else passed++;
    total++; if (out_data_a !== '0) $display("FAIL reset_out_data got %h want 0", out_data_a); else passed++;
    total++; if (drop_a !== 1'b0) $display("FAIL reset_drop got %b want 0", drop_a); else passed++;
    total++; if (out_valid_b !== 1'b0) $display("FAIL reset_out_valid_b got %b want 0", out_valid_b); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    q_a.delete(); q_b.delete();
    out_ready = 1'b1;
    in_valid = '1; in_data = V1; push_vec(V1);
    @(negedge clk);
    total++; if (in_ready_a !== 1'b1) $display("FAIL single_in_ready got %b want 1", in_ready_a); else passed++;
    total++; if (out_valid_a !== 1'b0) $display("FAIL single_pre_valid got %b want 0", out_valid_a); else passed++;
    tick();
    in_valid = '0;
    for (int c = 0; c < NN; c++) begin
      @(negedge clk);
      total++; if (out_valid_a !== 1'b1) $display("FAIL single_valid_c%0d got %b want 1", c, out_valid_a); else passed++;
      if (out_valid_a && out_ready) begin
        total++;
        if (q_a.size() == 0) $display("FAIL single_stream_a got %h want none", out_data_a);
        else begin
          e = q_a.pop_front();
          if ({out_data_a, out_index_a, out_last_a} !== e) $display("FAIL single_stream_a got %h/%0d/%b want %h/%0d/%b", out_data_a, out_index_a, out_last_a, e.data, e.idx, e.last);
          else passed++;
        end
      end
      if (out_valid_b && out_ready) begin
        total++;
        if (q_b.size() == 0) $display("FAIL single_stream_b got %h want none", out_data_b);
        else begin
          e = q_b.pop_front();
          if ({out_data_b, out_index_b, out_last_b} !== e) $display("FAIL single_stream_b got %h/%0d/%b want %h/%0d/%b", out_data_b, out_index_b, out_last_b, e.data, e.idx, e.last);
          else passed++;
        end
      end
      tick();
    end
    @(negedge clk);
    total++; if (out_valid_a !== 1'b0) $display("FAIL single_idle got %b want 0", out_valid_a); else passed++;
    total++; if (q_a.size() + q_b.size() != 0) $display("FAIL single_left got %0d want 0", q_a.size() + q_b.size()); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    exp_t e;
    q_a.delete(); q_b.delete();
    out_ready = 1'b1;
    in_valid = '1; in_data = V1; push_vec(V1);
    tick();
    in_valid = '0;
    for (int c = 0; c < NN + 3; c++) begin
      out_ready = !(c >= 1 && c <= 3);
      @(negedge clk);
      if (out_valid_a && !out_ready) begin
        total++;
        if (q_a.size() == 0) $display("FAIL bp_hold got %h want none", out_data_a);
        else if (out_data_a !== q_a[0].data) $display("FAIL bp_hold_c%0d got %h want %h", c, out_data_a, q_a[0].data);
        else passed++;
      end
      if (out_valid_a && out_ready) begin
        total++;
        if (q_a.size() == 0) $display("FAIL bp_stream_a got %h want none", out_data_a);
        else begin
          e = q_a.pop_front();
          if ({out_data_a, out_index_a, out_last_a} !== e) $display("FAIL bp_stream_a got %h/%0d/%b want %h/%0d/%b", out_data_a, out_index_a, out_last_a, e.data, e.idx, e.last);
          else passed++;
        end
      end
      if (out_valid_b && out_ready) begin
        total++;
        if (q_b.size() == 0) $display("FAIL bp_stream_b got %h want none", out_data_b);
        else begin
          e = q_b.pop_front();
          if ({out_data_b, out_index_b, out_last_b} !== e) $display("FAIL bp_stream_b got %h/%0d/%b want %h/%0d/%b", out_data_b, out_index_b, out_last_b, e.data, e.idx, e.last);
          else passed++;
        end
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid_a !== 1'b0) $display("FAIL bp_idle got %b want 0", out_valid_a); else passed++;
    total++; if (q_a.size() + q_b.size() != 0) $display("FAIL bp_left got %0d want 0", q_a.size() + q_b.size()); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic exp_rdy;
    q_a.delete(); q_b.delete();
    out_ready = 1'b1;
    in_valid = '1; in_data = V1; push_vec(V1);
    tick();
    in_valid = '0;
    for (int c = 0; c < 2 * NN; c++) begin
      if (c == 1) begin
        in_valid = '1; in_data = V2; push_vec(V2);
      end
      exp_rdy = !(c == 2 || c == 3);
      @(negedge clk);
      total++; if (out_valid_a !== 1'b1) $display("FAIL b2b_gap_c%0d got %b want 1", c, out_valid_a); else passed++;
      total++; if (in_ready_a !== exp_rdy) $display("FAIL b2b_in_ready_c%0d got %b want %b", c, in_ready_a, exp_rdy); else passed++;
      if (out_valid_a && out_ready) begin
        total++;
        if (q_a.size() == 0) $display("FAIL b2b_stream_a got %h want none", out_data_a);
        else begin
          e = q_a.pop_front();
          if ({out_data_a, out_index_a, out_last_a} !== e) $display("FAIL b2b_stream_a got %h/%0d/%b want %h/%0d/%b", out_data_a, out_index_a, out_last_a, e.data, e.idx, e.last);
          else passed++;
        end
      end
      if (out_valid_b && out_ready) begin
        total++;
        if (q_b.size() == 0) $display("FAIL b2b_stream_b got %h want none", out_data_b);
        else begin
          e = q_b.pop_front();
          if ({out_data_b, out_index_b, out_last_b} !== e) $display("FAIL b2b_stream_b got %h/%0d/%b want %h/%0d/%b", out_data_b, out_index_b, out_last_b, e.data, e.idx, e.last);
          else passed++;
        end
      end
      tick();
      in_valid = '0;
    end
    @(negedge clk);
    total++; if (out_valid_a !== 1'b0) $display("FAIL b2b_idle got %b want 0", out_valid_a); else passed++;
    total++; if (q_a.size() + q_b.size() != 0) $display("FAIL b2b_left got %0d want 0", q_a.size() + q_b.size()); else passed++;
    tick();
  endtask

  task automatic test_drop();
    exp_t e;
    q_a.delete(); q_b.delete();
    out_ready = 1'b1;
    in_valid = '1; in_data = V1; push_vec(V1);
    tick();
    in_valid = '0;
    for (int c = 0; c < 2 * NN + 2; c++) begin
      if (c == 1) begin
        in_valid = '1; in_data = V2; push_vec(V2);
      end
      if (c == 2) begin
        in_valid = '1; in_data = V3;
      end
      @(negedge clk);
      total++; if (drop_a !== (c == 3)) $display("FAIL drop_a_c%0d got %b want %b", c, drop_a, (c == 3)); else passed++;
      total++; if (drop_b !== (c == 3)) $display("FAIL drop_b_c%0d got %b want %b", c, drop_b, (c == 3)); else passed++;
      if (out_valid_a && out_ready) begin
        total++;
        if (q_a.size() == 0) $display("FAIL drop_stream_a got %h want none", out_data_a);
        else begin
          e = q_a.pop_front();
          if ({out_data_a, out_index_a, out_last_a} !== e) $display("FAIL drop_stream_a got %h/%0d/%b want %h/%0d/%b", out_data_a, out_index_a, out_last_a, e.data, e.idx, e.last);
          else passed++;
        end
      end
      if (out_valid_b && out_ready) begin
        total++;
        if (q_b.size() == 0) $display("FAIL drop_stream_b got %h want none", out_data_b);
        else begin
          e = q_b.pop_front();
          if ({out_data_b, out_index_b, out_last_b} !== e) $display("FAIL drop_stream_b got %h/%0d/%b want %h/%0d/%b", out_data_b, out_index_b, out_last_b, e.data, e.idx, e.last);
          else passed++;
        end
      end
      tick();
      in_valid = '0;
    end
    total++; if (q_a.size() + q_b.size() != 0) $display("FAIL drop_left got %0d want 0", q_a.size() + q_b.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    q_a.delete(); q_b.delete();
    out_ready = 1'b1;
    in_valid = '1; in_data = V1; push_vec(V1);
    tick();
    in_valid = '0;
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin
        in_valid = '1; in_data = V2;
      end
      @(negedge clk);
      if (out_valid_a && out_ready) begin
        total++;
        if (q_a.size() == 0) $display("FAIL rmid_stream_a got %h want none", out_data_a);
        else begin
          e = q_a.pop_front();
          if ({out_data_a, out_index_a, out_last_a} !== e) $display("FAIL rmid_stream_a got %h/%0d/%b want %h/%0d/%b", out_data_a, out_index_a, out_last_a, e.data, e.idx, e.last);
          else passed++;
        end
      end
      tick();
      in_valid = '0;
    end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid_a !== 1'b0) $display("FAIL rmid_out_valid got %b want 0", out_valid_a); else passed++;
    total++; if (out_index_a !== '0) $display("FAIL rmid_out_index got %0d want 0", out_index_a); else passed++;
    total++; if (out_data_a !== '0) $display("FAIL rmid_out_data got %h want 0", out_data_a); else passed++;
    total++; if (out_last_a !== 1'b0) $display("FAIL rmid_out_last got %b want 0", out_last_a); else passed++;
    total++; if (in_ready_a !== 1'b1) $display("FAIL rmid_in_ready got %b want 1", in_ready_a); else passed++;
    q_a.delete(); q_b.delete();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (out_valid_a !== 1'b0) $display("FAIL rmid_leftover_c%0d got %b want 0", c, out_valid_a); else passed++;
      tick();
    end
    in_valid = '1; in_data = V4; push_vec(V4);
    tick();
    in_valid = '0;
    for (int c = 0; c < NN; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++; if (out_index_a !== '0) $display("FAIL rmid_first_index got %0d want 0", out_index_a); else passed++;
      end
      if (out_valid_a && out_ready) begin
        total++;
        if (q_a.size() == 0) $display("FAIL rmid_new_a got %h want none", out_data_a);
        else begin
          e = q_a.pop_front();
          if ({out_data_a, out_index_a, out_last_a} !== e) $display("FAIL rmid_new_a got %h/%0d/%b want %h/%0d/%b", out_data_a, out_index_a, out_last_a, e.data, e.idx, e.last);
          else passed++;
        end
      end
      if (out_valid_b && out_ready) begin
        total++;
        if (q_b.size() == 0) $display("FAIL rmid_new_b got %h want none", out_data_b);
        else begin
          e = q_b.pop_front();
          if ({out_data_b, out_index_b, out_last_b} !== e) $display("FAIL rmid_new_b got %h/%0d/%b want %h/%0d/%b", out_data_b, out_index_b, out_last_b, e.data, e.idx, e.last);
          else passed++;
        end
      end
      tick();
    end
    total++; if (q_a.size() + q_b.size() != 0) $display("FAIL rmid_left got %0d want 0", q_a.size() + q_b.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
